// File: rtl/adbg_ahb3_pkg.sv
// Shared AHB3-Lite encodings for the debug bus master.
// Also holds the master FSM state type and the request legality check.
package adbg_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_B8  = 3'b000;
  localparam logic [2:0] HSIZE_B16 = 3'b001;
  localparam logic [2:0] HSIZE_B32 = 3'b010;
  localparam logic [2:0] HSIZE_B64 = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } bus_master_state_t;

  // A request is legal when its size fits the bus and the address is size-aligned.
  function automatic logic req_is_legal(input logic [2:0] size,
                                        input logic [2:0] addr_lo,
                                        input int unsigned max_size);
    logic [2:0] mask;
    case (size)
      3'd0:    mask = 3'b000;
      3'd1:    mask = 3'b001;
      3'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (32'(size) <= max_size) && ((addr_lo & mask) == 3'b000);
  endfunction

endpackage

// File: rtl/adbg_ahb3_bus_master_if.sv
// AHB3-Lite master-side bus bundle; master drives address/control/write data,
// slave returns read data, ready and response.
interface adbg_ahb3_bus_master_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic [XLEN-1:0] HRDATA;
  logic            HREADY;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/adbg_ahb3_lane_steer.sv
// Byte-lane steering: replicates right-justified write data across the bus and
// right-justifies/masks read data according to address low bits and size.
module adbg_ahb3_lane_steer #(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int LG  = $clog2(NB)
) (
  input  logic [2:0]      size_i,
  input  logic [LG-1:0]   addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] hwdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [LG-1:0]   lane_mask;
  logic [XLEN-1:0] rdata_sh;

  // lane_mask = bytes-per-beat minus one; saturates at the full bus width
  always_comb begin
    lane_mask = (size_i >= 3'(LG)) ? '1 : LG'((32'd1 << size_i) - 32'd1);
  end

  assign rdata_sh = rdata_i >> {addr_lo_i, 3'b000};

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [LG-1:0] src;
    assign src = LG'(gi) & lane_mask;
    assign hwdata_o[gi*8 +: 8] = wdata_i[{src, 3'b000} +: 8];
    assign rdata_o[gi*8 +: 8]  = (LG'(gi) <= lane_mask) ? rdata_sh[gi*8 +: 8] : 8'h00;
  end

endmodule

// File: rtl/adbg_ahb3_bus_master.sv
// AHB3-Lite single-transfer master: one read or write per request, with
// lane steering, wait states, sticky error capture and rejection of illegal requests.
module adbg_ahb3_bus_master
  import adbg_ahb3_pkg::*;
#(
  parameter int         PLEN      = 32,
  parameter int         XLEN      = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_size_i,
  input  logic [PLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  adbg_ahb3_bus_master_if.master ahb_m
);

  localparam int NB = XLEN / 8;
  localparam int LG = $clog2(NB);

  bus_master_state_t state_q, state_d;

  logic            ready_q, ready_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [LG-1:0]   addr_lo_q, addr_lo_d;
  logic            err_q, err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  logic            hsel_q, hsel_d;
  logic [PLEN-1:0] haddr_q, haddr_d;
  logic [XLEN-1:0] hwdata_q, hwdata_d;
  logic            hwrite_q, hwrite_d;
  logic [2:0]      hsize_q, hsize_d;
  logic [1:0]      htrans_q, htrans_d;

  logic [XLEN-1:0] steer_hwdata;
  logic [XLEN-1:0] steer_rdata;
  logic            handshake;
  logic            rsp_err_now;

  // HWRITE/HSIZE stay valid after the address phase, so they double as the request latch.
  adbg_ahb3_lane_steer #(.XLEN(XLEN)) u_lane_steer (
    .size_i    (hsize_q),
    .addr_lo_i (addr_lo_q),
    .wdata_i   (wdata_q),
    .rdata_i   (ahb_m.HRDATA),
    .hwdata_o  (steer_hwdata),
    .rdata_o   (steer_rdata)
  );

  assign handshake   = req_valid_i & ready_q;
  assign rsp_err_now = err_q | (ahb_m.HRESP == HRESP_ERROR);

  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    addr_lo_d   = addr_lo_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    hsel_d      = hsel_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    htrans_d    = htrans_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          if (!req_is_legal(req_size_i, req_addr_i[2:0], LG)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = ST_ADDR;
            wdata_d   = req_wdata_i;
            addr_lo_d = req_addr_i[LG-1:0];
            err_d     = 1'b0;
            hsel_d    = 1'b1;
            htrans_d  = HTRANS_NONSEQ;
            haddr_d   = req_addr_i;
            hwrite_d  = req_we_i;
            hsize_d   = req_size_i;
          end
        end
      end
      ST_ADDR: begin
        if (ahb_m.HREADY) begin
          state_d  = ST_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          hwdata_d = steer_hwdata;
        end
      end
      ST_DATA: begin
        if (ahb_m.HREADY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = rsp_err_now;
          // Errored transfers and writes return no data.
          rsp_rdata_d = (hwrite_q || rsp_err_now) ? '0 : steer_rdata;
        end else if (ahb_m.HRESP == HRESP_ERROR) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      wdata_q     <= '0;
      addr_lo_q   <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= HSIZE_B8;
      htrans_q    <= HTRANS_IDLE;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      wdata_q     <= wdata_d;
      addr_lo_q   <= addr_lo_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      hsel_q      <= hsel_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      htrans_q    <= htrans_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_err_o       = rsp_err_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign ahb_m.HSEL      = hsel_q;
  assign ahb_m.HADDR     = haddr_q;
  assign ahb_m.HWDATA    = hwdata_q;
  assign ahb_m.HWRITE    = hwrite_q;
  assign ahb_m.HSIZE     = hsize_q;
  assign ahb_m.HTRANS    = htrans_q;
  assign ahb_m.HBURST    = HBURST_SINGLE;
  assign ahb_m.HPROT     = HPROT_VAL;
  assign ahb_m.HMASTLOCK = 1'b0;

endmodule
